// File: rtl/mem_bank_wrap_if.sv
// Request/response bundle of the banked SRAM wrapper: active-low CSN/WEN/BEN
// requests from the core-side mux, read data with a valid strobe and a ready flag.
interface mem_bank_wrap_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
);
   localparam int NB = DATA_WIDTH / 8;

   logic                  CSN;
   logic                  WEN;
   logic [ADDR_WIDTH-1:0] A;
   logic [DATA_WIDTH-1:0] D;
   logic [NB-1:0]         BEN;
   logic [DATA_WIDTH-1:0] Q;
   logic                  RVALID;
   logic                  RDY;

   modport master (
      output CSN, WEN, A, D, BEN,
      input  Q, RVALID, RDY
   );

   modport slave (
      input  CSN, WEN, A, D, BEN,
      output Q, RVALID, RDY
   );
endinterface

// File: rtl/mem_bank_wrap.sv
// Parametrised single-port SRAM wrapper: depth-banked generic cuts, optional Q
// register, read-valid strobe and a post-reset zero-initialisation sequencer.
module mem_bank_wrap #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int NUM_BANKS  = 2,
   parameter int OUT_REG    = 0,
   parameter int INIT_ZERO  = 1
) (
   input logic          CLK,
   input logic          RSTN,
   mem_bank_wrap_if.slave bus
);
   localparam int NB        = DATA_WIDTH / 8;
   localparam int LOG_NB    = $clog2(NUM_BANKS);
   localparam int BANK_BITS = (LOG_NB > 0) ? LOG_NB : 1;
   localparam int ROW_BITS  = ADDR_WIDTH - LOG_NB;
   localparam int ROWS      = 2 ** ROW_BITS;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_INIT  = 2'd1,
      ST_READY = 2'd2
   } state_t;

   state_t                state_q;
   logic [ROW_BITS-1:0]   ic_q;
   logic                  rdy_q;
   logic                  v1_q;
   logic                  v2_q;
   logic [BANK_BITS-1:0]  rbank_q;
   logic [DATA_WIDTH-1:0] q_q;

   logic [BANK_BITS-1:0]  bank_s;
   logic [ROW_BITS-1:0]   row_s;
   logic                  acc_s;
   logic                  rd_acc_s;
   logic                  wr_acc_s;
   logic                  init_we_s;
   logic [DATA_WIDTH-1:0] q_mux_s;
   logic [DATA_WIDTH-1:0] bank_dout_s [NUM_BANKS];

   assign row_s = bus.A[ROW_BITS-1:0];

   generate
      if (LOG_NB > 0) begin : g_bsel
         assign bank_s = bus.A[ADDR_WIDTH-1 -: LOG_NB];
      end else begin : g_bsel_one
         assign bank_s = 1'b0;
      end
   endgenerate

   // Nothing reaches the array on an edge where RSTN is low.
   assign acc_s     = ~bus.CSN & rdy_q & RSTN;
   assign rd_acc_s  = acc_s & bus.WEN;
   assign wr_acc_s  = acc_s & ~bus.WEN;
   assign init_we_s = (state_q == ST_INIT) & RSTN;

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state_q <= ST_RESET;
         ic_q    <= '0;
         rdy_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_RESET: begin
               if (INIT_ZERO != 0) begin
                  state_q <= ST_INIT;
                  rdy_q   <= 1'b0;
               end else begin
                  state_q <= ST_READY;
                  rdy_q   <= 1'b1;
               end
            end
            ST_INIT: begin
               if (&ic_q) begin
                  state_q <= ST_READY;
                  rdy_q   <= 1'b1;
               end else begin
                  ic_q    <= ic_q + ROW_BITS'(1);
                  rdy_q   <= 1'b0;
               end
            end
            ST_READY: begin
               rdy_q <= 1'b1;
            end
            default: begin
               state_q <= ST_RESET;
               rdy_q   <= 1'b0;
            end
         endcase
      end
   end

   genvar b;
   generate
      for (b = 0; b < NUM_BANKS; b++) begin : g_bank
         logic [DATA_WIDTH-1:0] mem_q [ROWS];
         logic [DATA_WIDTH-1:0] dout_q;
         logic                  sel_s;

         assign sel_s = (bank_s == BANK_BITS'(b));

         // Array contents survive RSTN; only the INIT sweep clears them.
         always_ff @(posedge CLK) begin
            if (init_we_s) begin
               mem_q[ic_q] <= '0;
            end else if (wr_acc_s && sel_s) begin
               for (int i = 0; i < NB; i++) begin
                  if (!bus.BEN[i]) begin
                     mem_q[row_s][i*8 +: 8] <= bus.D[i*8 +: 8];
                  end
               end
            end
            if (rd_acc_s && sel_s) begin
               dout_q <= mem_q[row_s];
            end
         end

         assign bank_dout_s[b] = dout_q;
      end
   endgenerate

   always_comb begin
      q_mux_s = '0;
      for (int k = 0; k < NUM_BANKS; k++) begin
         q_mux_s = (rbank_q == BANK_BITS'(k)) ? bank_dout_s[k] : q_mux_s;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         rbank_q <= '0;
         q_q     <= '0;
      end else begin
         v1_q <= rd_acc_s;
         v2_q <= v1_q;
         if (rd_acc_s) begin
            rbank_q <= bank_s;
         end
         if (v1_q) begin
            q_q <= q_mux_s;
         end
      end
   end

   assign bus.Q      = (OUT_REG != 0) ? q_q  : q_mux_s;
   assign bus.RVALID = (OUT_REG != 0) ? v2_q : v1_q;
   assign bus.RDY    = rdy_q;
endmodule

// File: tb/tb_mem_bank_wrap.sv
// Directed bench: two 32-bit/4-bank wrappers (Q direct and registered) share one
// stimulus stream; a 64-bit single-bank wrapper without INIT runs alongside.
module tb_mem_bank_wrap;
   logic clk;
   logic rstn;
   int   checks = 0;
   int   errors = 0;

   mem_bank_wrap_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) if_a ();
   mem_bank_wrap_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) if_b ();
   mem_bank_wrap_if #(.DATA_WIDTH(64), .ADDR_WIDTH(6)) if_c ();

   assign if_b.CSN = if_a.CSN;
   assign if_b.WEN = if_a.WEN;
   assign if_b.A   = if_a.A;
   assign if_b.D   = if_a.D;
   assign if_b.BEN = if_a.BEN;

   mem_bank_wrap #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_BANKS(4), .OUT_REG(0), .INIT_ZERO(1))
      dut_a (.CLK(clk), .RSTN(rstn), .bus(if_a));
   mem_bank_wrap #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_BANKS(4), .OUT_REG(1), .INIT_ZERO(1))
      dut_b (.CLK(clk), .RSTN(rstn), .bus(if_b));
   mem_bank_wrap #(.DATA_WIDTH(64), .ADDR_WIDTH(6), .NUM_BANKS(1), .OUT_REG(0), .INIT_ZERO(0))
      dut_c (.CLK(clk), .RSTN(rstn), .bus(if_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req_a(input logic csn, input logic wen, input logic [5:0] addr,
                        input logic [31:0] d, input logic [3:0] ben);
      if_a.CSN = csn;
      if_a.WEN = wen;
      if_a.A   = addr;
      if_a.D   = d;
      if_a.BEN = ben;
   endtask

   task automatic req_c(input logic csn, input logic wen, input logic [5:0] addr,
                        input logic [63:0] d, input logic [7:0] ben);
      if_c.CSN = csn;
      if_c.WEN = wen;
      if_c.A   = addr;
      if_c.D   = d;
      if_c.BEN = ben;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      req_a(1'b1, 1'b1, 6'h00, 32'h0, 4'hF);
      req_c(1'b1, 1'b1, 6'h00, 64'h0, 8'hFF);
      tick();
      tick();
      checks++; if (if_a.RDY !== 1'b0) begin errors++; $display("FAIL reset_rdy_a: got %b want 0", if_a.RDY); end
      checks++; if (if_a.RVALID !== 1'b0) begin errors++; $display("FAIL reset_rvalid_a: got %b want 0", if_a.RVALID); end
      checks++; if (if_b.RVALID !== 1'b0) begin errors++; $display("FAIL reset_rvalid_b: got %b want 0", if_b.RVALID); end
      checks++; if (if_b.Q !== 32'h0) begin errors++; $display("FAIL reset_q_b: got %h want 00000000", if_b.Q); end
      checks++; if (if_c.RDY !== 1'b0) begin errors++; $display("FAIL reset_rdy_c: got %b want 0", if_c.RDY); end
   endtask

   task automatic read_all_zero(input string tag);
      for (int k = 0; k <= 64; k++) begin
         if (k < 64) req_a(1'b0, 1'b1, 6'(k), 32'h0, 4'hF);
         else        req_a(1'b1, 1'b1, 6'h00, 32'h0, 4'hF);
         tick();
         if (k < 64) begin
            checks++; if (if_a.RVALID !== 1'b1) begin errors++; $display("FAIL %s_rv_a[%0d]: got %b want 1", tag, k, if_a.RVALID); end
            checks++; if (if_a.Q !== 32'h0) begin errors++; $display("FAIL %s_q_a[%0d]: got %h want 00000000", tag, k, if_a.Q); end
         end
         if (k > 0) begin
            checks++; if (if_b.RVALID !== 1'b1) begin errors++; $display("FAIL %s_rv_b[%0d]: got %b want 1", tag, k-1, if_b.RVALID); end
            checks++; if (if_b.Q !== 32'h0) begin errors++; $display("FAIL %s_q_b[%0d]: got %h want 00000000", tag, k-1, if_b.Q); end
         end
      end
      tick();
      checks++; if (if_a.RVALID !== 1'b0) begin errors++; $display("FAIL %s_rv_a_end: got %b want 0", tag, if_a.RVALID); end
      checks++; if (if_b.RVALID !== 1'b0) begin errors++; $display("FAIL %s_rv_b_end: got %b want 0", tag, if_b.RVALID); end
   endtask

   task automatic test_init_dropped();
      // A write held at address 0 throughout INIT must be dropped.
      rstn = 1'b1;
      req_a(1'b0, 1'b0, 6'h00, 32'hFFFF_FFFF, 4'h0);
      for (int i = 1; i <= 17; i++) begin
         tick();
         checks++; if (if_a.RDY !== (i == 17)) begin errors++; $display("FAIL init_rdy_a[%0d]: got %b want %b", i, if_a.RDY, (i == 17)); end
         checks++; if (if_b.RDY !== (i == 17)) begin errors++; $display("FAIL init_rdy_b[%0d]: got %b want %b", i, if_b.RDY, (i == 17)); end
         checks++; if (if_a.RVALID !== 1'b0) begin errors++; $display("FAIL init_rv_a[%0d]: got %b want 0", i, if_a.RVALID); end
         checks++; if (if_b.RVALID !== 1'b0) begin errors++; $display("FAIL init_rv_b[%0d]: got %b want 0", i, if_b.RVALID); end
         if (i == 1) begin
            checks++; if (if_c.RDY !== 1'b1) begin errors++; $display("FAIL noinit_rdy_c: got %b want 1", if_c.RDY); end
         end
      end
      req_a(1'b1, 1'b1, 6'h00, 32'h0, 4'hF);
      read_all_zero("init");
   endtask

   task automatic test_byte_write();
      req_a(1'b0, 1'b0, 6'h15, 32'hAABB_CCDD, 4'b0000);
      tick();
      checks++; if (if_a.RVALID !== 1'b0) begin errors++; $display("FAIL bw_wr1_rv_a: got %b want 0", if_a.RVALID); end
      req_a(1'b0, 1'b0, 6'h15, 32'h1122_3344, 4'b1010);
      tick();
      checks++; if (if_a.RVALID !== 1'b0) begin errors++; $display("FAIL bw_wr2_rv_a: got %b want 0", if_a.RVALID); end
      req_a(1'b0, 1'b1, 6'h15, 32'h0, 4'hF);
      tick();
      checks++; if (if_a.RVALID !== 1'b1) begin errors++; $display("FAIL bw_rv_a: got %b want 1", if_a.RVALID); end
      checks++; if (if_a.Q !== 32'hAA22_CC44) begin errors++; $display("FAIL bw_q_a: got %h want aa22cc44", if_a.Q); end
      checks++; if (if_b.RVALID !== 1'b0) begin errors++; $display("FAIL bw_rv_b_early: got %b want 0", if_b.RVALID); end
      req_a(1'b1, 1'b1, 6'h00, 32'h0, 4'hF);
      tick();
      checks++; if (if_a.RVALID !== 1'b0) begin errors++; $display("FAIL bw_rv_a_once: got %b want 0", if_a.RVALID); end
      checks++; if (if_a.Q !== 32'hAA22_CC44) begin errors++; $display("FAIL bw_q_a_hold: got %h want aa22cc44", if_a.Q); end
      checks++; if (if_b.RVALID !== 1'b1) begin errors++; $display("FAIL bw_rv_b: got %b want 1", if_b.RVALID); end
      checks++; if (if_b.Q !== 32'hAA22_CC44) begin errors++; $display("FAIL bw_q_b: got %h want aa22cc44", if_b.Q); end
      tick();
      checks++; if (if_b.RVALID !== 1'b0) begin errors++; $display("FAIL bw_rv_b_once: got %b want 0", if_b.RVALID); end
   endtask

   task automatic test_bank_cross();
      logic [5:0]  addr [4];
      logic [31:0] pat  [4];
      addr[0] = 6'h0F; pat[0] = 32'hDEAD_000F;
      addr[1] = 6'h10; pat[1] = 32'hBEEF_0010;
      addr[2] = 6'h2F; pat[2] = 32'hCAFE_002F;
      addr[3] = 6'h30; pat[3] = 32'hF00D_0030;
      for (int i = 0; i < 4; i++) begin
         req_a(1'b0, 1'b0, addr[i], pat[i], 4'h0);
         tick();
      end
      for (int i = 0; i <= 4; i++) begin
         if (i < 4) req_a(1'b0, 1'b1, addr[i], 32'h0, 4'hF);
         else       req_a(1'b1, 1'b1, 6'h00, 32'h0, 4'hF);
         tick();
         if (i < 4) begin
            checks++; if (if_a.RVALID !== 1'b1) begin errors++; $display("FAIL bx_rv_a[%0d]: got %b want 1", i, if_a.RVALID); end
            checks++; if (if_a.Q !== pat[i]) begin errors++; $display("FAIL bx_q_a[%0d]: got %h want %h", i, if_a.Q, pat[i]); end
         end
         if (i > 0) begin
            checks++; if (if_b.RVALID !== 1'b1) begin errors++; $display("FAIL bx_rv_b[%0d]: got %b want 1", i-1, if_b.RVALID); end
            checks++; if (if_b.Q !== pat[i-1]) begin errors++; $display("FAIL bx_q_b[%0d]: got %h want %h", i-1, if_b.Q, pat[i-1]); end
         end
      end
      tick();
      tick();
      checks++; if (if_a.RVALID !== 1'b0) begin errors++; $display("FAIL bx_rv_a_idle: got %b want 0", if_a.RVALID); end
      checks++; if (if_a.Q !== pat[3]) begin errors++; $display("FAIL bx_q_a_hold: got %h want %h", if_a.Q, pat[3]); end
      checks++; if (if_b.RVALID !== 1'b0) begin errors++; $display("FAIL bx_rv_b_idle: got %b want 0", if_b.RVALID); end
      checks++; if (if_b.Q !== pat[3]) begin errors++; $display("FAIL bx_q_b_hold: got %h want %h", if_b.Q, pat[3]); end
   endtask

   task automatic test_back_to_back();
      req_a(1'b0, 1'b0, 6'h05, 32'h5A5A_5A5A, 4'h0);
      tick();
      req_a(1'b0, 1'b1, 6'h05, 32'h0, 4'hF);
      tick();
      checks++; if (if_a.Q !== 32'h5A5A_5A5A || if_a.RVALID !== 1'b1) begin errors++; $display("FAIL b2b_wr_rd_a: got %h/%b want 5a5a5a5a/1", if_a.Q, if_a.RVALID); end
      req_a(1'b0, 1'b0, 6'h06, 32'h0102_0304, 4'h0);
      tick();
      checks++; if (if_a.RVALID !== 1'b0) begin errors++; $display("FAIL b2b_wr_rv_a: got %b want 0", if_a.RVALID); end
      checks++; if (if_b.Q !== 32'h5A5A_5A5A || if_b.RVALID !== 1'b1) begin errors++; $display("FAIL b2b_wr_rd_b: got %h/%b want 5a5a5a5a/1", if_b.Q, if_b.RVALID); end
      req_a(1'b0, 1'b1, 6'h06, 32'h0, 4'hF);
      tick();
      checks++; if (if_a.Q !== 32'h0102_0304) begin errors++; $display("FAIL b2b_rd06_a: got %h want 01020304", if_a.Q); end
      req_a(1'b0, 1'b1, 6'h15, 32'h0, 4'hF);
      tick();
      checks++; if (if_a.Q !== 32'hAA22_CC44 || if_a.RVALID !== 1'b1) begin errors++; $display("FAIL b2b_rd15_a: got %h/%b want aa22cc44/1", if_a.Q, if_a.RVALID); end
      checks++; if (if_b.Q !== 32'h0102_0304) begin errors++; $display("FAIL b2b_rd06_b: got %h want 01020304", if_b.Q); end
      req_a(1'b1, 1'b1, 6'h00, 32'h0, 4'hF);
      tick();
      checks++; if (if_b.Q !== 32'hAA22_CC44) begin errors++; $display("FAIL b2b_rd15_b: got %h want aa22cc44", if_b.Q); end
      tick();
   endtask

   task automatic test_mid_init_reset();
      req_a(1'b1, 1'b1, 6'h00, 32'h0, 4'hF);
      rstn = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
      // One edge leaves RESET, nine more sweep rows 0..8: INIT now sits on row 9.
      for (int i = 1; i <= 10; i++) tick();
      checks++; if (if_a.RDY !== 1'b0) begin errors++; $display("FAIL mid_rdy_pre: got %b want 0", if_a.RDY); end
      rstn = 1'b0;
      tick();
      checks++; if (if_b.RVALID !== 1'b0 || if_b.Q !== 32'h0) begin errors++; $display("FAIL mid_b_reset: got %b/%h want 0/00000000", if_b.RVALID, if_b.Q); end
      rstn = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         tick();
         checks++; if (if_a.RDY !== (i == 17)) begin errors++; $display("FAIL mid_rdy_a[%0d]: got %b want %b", i, if_a.RDY, (i == 17)); end
         if (i == 1) begin
            checks++; if (if_c.RDY !== 1'b1) begin errors++; $display("FAIL mid_rdy_c: got %b want 1", if_c.RDY); end
         end
      end
      read_all_zero("midinit");
   endtask

   task automatic test_wide();
      req_c(1'b0, 1'b0, 6'h2A, 64'h0123_4567_89AB_CDEF, 8'h00);
      tick();
      checks++; if (if_c.RVALID !== 1'b0) begin errors++; $display("FAIL wide_wr_rv: got %b want 0", if_c.RVALID); end
      req_c(1'b0, 1'b1, 6'h2A, 64'h0, 8'hFF);
      tick();
      checks++; if (if_c.RVALID !== 1'b1) begin errors++; $display("FAIL wide_rv: got %b want 1", if_c.RVALID); end
      checks++; if (if_c.Q !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL wide_q: got %h want 0123456789abcdef", if_c.Q); end
      req_c(1'b0, 1'b0, 6'h2A, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0);
      tick();
      req_c(1'b0, 1'b1, 6'h2A, 64'h0, 8'hFF);
      tick();
      checks++; if (if_c.Q !== 64'h0123_4567_FFFF_FFFF) begin errors++; $display("FAIL wide_bytes: got %h want 01234567ffffffff", if_c.Q); end
      req_c(1'b1, 1'b1, 6'h00, 64'h0, 8'hFF);
      tick();
      checks++; if (if_c.RVALID !== 1'b0 || if_c.Q !== 64'h0123_4567_FFFF_FFFF) begin errors++; $display("FAIL wide_hold: got %b/%h want 0/01234567ffffffff", if_c.RVALID, if_c.Q); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_init_dropped();
      test_byte_write();
      test_bank_cross();
      test_back_to_back();
      test_mid_init_reset();
      test_wide();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
